// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: snoops a multiplexed seven-segment dig/smg bus and rebuilds the six displayed
// BCD digits plus DP flags, publishing them one whole frame at a time. Define SEG_DEC_ERRCNT_EN for err_cnt.
module seg_scan_decoder #(
  parameter int unsigned STABLE_CYC  = 4,
  parameter int unsigned TIMEOUT_CYC = 65535
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] dig,
  input  logic [7:0] smg,
  input  logic       err_clr,
  output logic [3:0] q0,
  output logic [3:0] q1,
  output logic [3:0] q2,
  output logic [3:0] q3,
  output logic [3:0] q4,
  output logic [3:0] q5,
  output logic [5:0] dp,
  output logic       frame_stb,
  output logic       alive,
  output logic       seg_err,
  output logic [7:0] err_cnt
);

  localparam int unsigned NDIG = 6;
  localparam int unsigned IW   = 14;
  localparam int unsigned SCW  = 8;
  localparam int unsigned TW   = 16;
  localparam logic [SCW-1:0] CAP_AT  = SCW'(STABLE_CYC - 1);
  localparam logic [TW-1:0]  TMO_LIM = TW'(TIMEOUT_CYC);

  logic [IW-1:0]  in_r;
  logic [SCW-1:0] stab_cnt;
  logic [TW-1:0]  tmo_cnt;
  logic [NDIG-1:0] seen;
  logic [NDIG-1:0] dp_sh;
  logic [3:0]      shadow [NDIG];
  logic [3:0]      qv     [NDIG];

  logic [NDIG-1:0] sel;
  logic [NDIG-1:0] sel_vec;
  logic [3:0]      code;
  logic            cap;
  logic            idle;
  logic            legal;
  logic            wr;
  logic            commit;
  logic            err_ev;
  logic [TW-1:0]   tmo_nxt;
  logic [3:0]      sh_byp [NDIG];
  logic [NDIG-1:0] dp_byp;

  function automatic logic [3:0] seg_decode(input logic [6:0] s);
    case (s)
      7'h7E:   return 4'd0;
      7'h30:   return 4'd1;
      7'h6D:   return 4'd2;
      7'h79:   return 4'd3;
      7'h33:   return 4'd4;
      7'h5B:   return 4'd5;
      7'h5F:   return 4'd6;
      7'h70:   return 4'd7;
      7'h7F:   return 4'd8;
      7'h7B:   return 4'd9;
      7'h00:   return 4'hE;
      default: return 4'hF;
    endcase
  endfunction

  // Capture qualification, decode and frame-completion detection
  always_comb begin
    sel     = ~in_r[IW-1:8];
    sel_vec = '0;
    for (int n = 0; n < NDIG; n++) begin
      sel_vec[n] = sel[NDIG-1-n];
    end
    cap     = (stab_cnt == CAP_AT);
    idle    = (sel == '0);
    legal   = !idle && ((sel & (sel - 6'd1)) == '0);
    code    = seg_decode(in_r[6:0]);
    wr      = cap && legal;
    commit  = wr && ((seen | sel_vec) == '1);
    err_ev  = cap && ((!idle && !legal) || (legal && (code == 4'hF)));
    dp_byp  = dp_sh;
    for (int n = 0; n < NDIG; n++) begin
      sh_byp[n] = sel_vec[n] ? code : shadow[n];
      if (sel_vec[n]) dp_byp[n] = in_r[7];
    end
    if (commit)              tmo_nxt = '0;
    else if (tmo_cnt == '1)  tmo_nxt = tmo_cnt;
    else                     tmo_nxt = tmo_cnt + TW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      in_r      <= '0;
      stab_cnt  <= '0;
      tmo_cnt   <= '0;
      seen      <= '0;
      dp_sh     <= '0;
      dp        <= '0;
      frame_stb <= 1'b0;
      alive     <= 1'b0;
      seg_err   <= 1'b0;
      for (int n = 0; n < NDIG; n++) begin
        shadow[n] <= '0;
        qv[n]     <= '0;
      end
    end else begin
      in_r <= {dig, smg};
      if ({dig, smg} != in_r)    stab_cnt <= '0;
      else if (stab_cnt != '1)   stab_cnt <= stab_cnt + SCW'(1);

      if (wr) begin
        for (int n = 0; n < NDIG; n++) shadow[n] <= sh_byp[n];
        dp_sh <= dp_byp;
        seen  <= commit ? '0 : (seen | sel_vec);
      end

      // Publish the whole frame, bypassing the digit captured this cycle
      if (commit) begin
        for (int n = 0; n < NDIG; n++) qv[n] <= sh_byp[n];
        dp <= dp_byp;
      end
      frame_stb <= commit;

      tmo_cnt <= tmo_nxt;
      if (commit)                  alive <= 1'b1;
      else if (tmo_nxt >= TMO_LIM) alive <= 1'b0;

      if (err_ev)       seg_err <= 1'b1;
      else if (err_clr) seg_err <= 1'b0;
    end
  end

`ifdef SEG_DEC_ERRCNT_EN
  // An error coinciding with a clear restarts the count at one
  always_ff @(posedge clk) begin
    if (!rst_n)                err_cnt <= '0;
    else if (err_ev) begin
      if (err_clr)             err_cnt <= 8'd1;
      else if (err_cnt != '1)  err_cnt <= err_cnt + 8'd1;
    end else if (err_clr)      err_cnt <= '0;
  end
`else
  assign err_cnt = '0;
`endif

  assign q0 = qv[0];
  assign q1 = qv[1];
  assign q2 = qv[2];
  assign q3 = qv[3];
  assign q4 = qv[4];
  assign q5 = qv[5];

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Self-checking bench for seg_scan_decoder: directed scenarios plus randomized scans against a
// digit-level reference model (honours SEG_DEC_ERRCNT_EN for err_cnt expectations).
module tb_seg_scan_decoder;

  localparam int S   = 4;
  localparam int TMO = 100;
  localparam logic [13:0] IDLE = 14'h3F00;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] dig;
  logic [7:0] smg;
  logic       err_clr;
  logic [3:0] q0, q1, q2, q3, q4, q5;
  logic [5:0] dp;
  logic       frame_stb, alive, seg_err;
  logic [7:0] err_cnt;
  logic [3:0] qd [6];

  seg_scan_decoder #(.STABLE_CYC(S), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .dig(dig), .smg(smg), .err_clr(err_clr),
    .q0(q0), .q1(q1), .q2(q2), .q3(q3), .q4(q4), .q5(q5), .dp(dp),
    .frame_stb(frame_stb), .alive(alive), .seg_err(seg_err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  assign qd[0] = q0;
  assign qd[1] = q1;
  assign qd[2] = q2;
  assign qd[3] = q3;
  assign qd[4] = q4;
  assign qd[5] = q5;

  int vectors = 0;
  int miscompares = 0;

  // Frame strobe and alive-fall observation on the inactive edge
  int   cyc = 0;
  int   stb_total = 0;
  int   stb_cyc = 0;
  int   fall_cyc = 0;
  logic alive_q = 1'b0;
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (frame_stb === 1'b1) begin
      stb_total = stb_total + 1;
      stb_cyc   = cyc;
    end
    if (alive_q === 1'b1 && alive === 1'b0) fall_cyc = cyc;
    alive_q = alive;
  end

  // Reference model: what the display scan has shown, tracked per digit
  logic [6:0]  pat [10] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h7B};
  logic [3:0]  mq [6];
  logic [3:0]  msh [6];
  logic [5:0]  mdp, mdpsh, mseen;
  logic        merr;
  logic [7:0]  mcnt;
  int          mframes = 0;
  logic [13:0] last_v;

  function automatic logic [5:0] dsel(input int n);
    return ~(6'b100000 >> n);
  endfunction

  function automatic logic [6:0] seg_of(input logic [3:0] c);
    logic [6:0] r;
    r = 7'h00;
    if (c < 4'd10) r = pat[c];
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 6; i++) begin mq[i] = 4'h0; msh[i] = 4'h0; end
    mdp = '0; mdpsh = '0; mseen = '0; merr = 1'b0; mcnt = '0;
  endtask

  task automatic model_err();
    merr = 1'b1;
`ifdef SEG_DEC_ERRCNT_EN
    if (mcnt != 8'hFF) mcnt = mcnt + 8'd1;
`endif
  endtask

  task automatic model_dwell(input logic [5:0] d, input logic [7:0] s, input int h);
    int zeros, n;
    logic [3:0] c;
    if (h < S || d == 6'h3F) return;
    zeros = 0; n = 0;
    for (int i = 0; i < 6; i++) if (d[5-i] == 1'b0) begin zeros++; n = i; end
    if (zeros != 1) begin model_err(); return; end
    c = 4'hF;
    if (s[6:0] == 7'h00) c = 4'hE;
    for (int i = 0; i < 10; i++) if (s[6:0] == pat[i]) c = 4'(i);
    if (c == 4'hF) model_err();
    msh[n] = c; mdpsh[n] = s[7]; mseen[n] = 1'b1;
    if (mseen == 6'h3F) begin
      for (int i = 0; i < 6; i++) mq[i] = msh[i];
      mdp = mdpsh; mseen = '0; mframes++;
    end
  endtask

  // Drive one value for h cycles; identical back-to-back values get a 1-cycle idle separator
  task automatic dwell(input logic [5:0] d, input logic [7:0] s, input int h);
    if ({d, s} == last_v && {d, s} != IDLE) begin
      dig = 6'h3F; smg = 8'h00;
      @(negedge clk);
    end
    dig = d; smg = s;
    repeat (h) @(negedge clk);
    last_v = {d, s};
    model_dwell(d, s, h);
  endtask

  task automatic scan_frame(input logic [23:0] codes, input logic [5:0] dps, input int h);
    for (int n = 0; n < 6; n++) dwell(dsel(n), {dps[n], seg_of(codes[4*n +: 4])}, h);
    dwell(6'h3F, 8'h00, S + 2);
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    merr = 1'b0; mcnt = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; err_clr = 1'b0; dig = 6'h3F; smg = 8'h00; last_v = IDLE;
    model_reset();
    repeat (3) @(negedge clk);
    for (int n = 0; n < 6; n++) begin
      vectors++;
      if (qd[n] !== 4'h0) begin miscompares++; $display("FAIL reset_q%0d: got %h want 0", n, qd[n]); end
    end
    vectors++;
    if ({dp, frame_stb, alive, seg_err, err_cnt} !== 17'h0) begin
      miscompares++;
      $display("FAIL reset_flags: dp=%b stb=%b alive=%b err=%b cnt=%0d, all want 0", dp, frame_stb, alive, seg_err, err_cnt);
    end
    rst_n = 1'b1;
    dwell(6'h3F, 8'h00, S + 2);
  endtask

  task automatic test_basic_frame();
    scan_frame(24'h654321, 6'b010100, 8);
    for (int n = 0; n < 6; n++) begin
      vectors++;
      if (qd[n] !== 4'(n + 1)) begin miscompares++; $display("FAIL basic_q%0d: got %h want %h", n, qd[n], n + 1); end
    end
    vectors++;
    if (dp !== 6'b010100) begin miscompares++; $display("FAIL basic_dp: got %b want 010100", dp); end
    vectors++;
    if (stb_total !== 1) begin miscompares++; $display("FAIL basic_stb: got %0d pulses want 1", stb_total); end
    vectors++;
    if (alive !== 1'b1 || seg_err !== 1'b0) begin
      miscompares++; $display("FAIL basic_alive_err: alive=%b err=%b want 1/0", alive, seg_err);
    end
  endtask

  task automatic test_glitch();
    int stb0 = stb_total;
    for (int n = 0; n < 3; n++) dwell(dsel(n), {1'b0, pat[7]}, 8);
    dwell(dsel(3), {1'b0, pat[9]}, S - 1);
    dwell(dsel(3), 8'h12, S - 1);
    for (int n = 4; n < 6; n++) dwell(dsel(n), {1'b0, pat[7]}, 8);
    dwell(6'h3F, 8'h00, S + 2);
    vectors++;
    if (stb_total !== stb0) begin miscompares++; $display("FAIL glitch_stb: got %0d want %0d", stb_total, stb0); end
    vectors++;
    if (q3 !== 4'd4 || seg_err !== 1'b0) begin
      miscompares++; $display("FAIL glitch_q3: q3=%h err=%b want 4/0", q3, seg_err);
    end
    dwell(dsel(3), {1'b1, pat[8]}, S);
    dwell(6'h3F, 8'h00, S + 2);
    vectors++;
    if (stb_total !== stb0 + 1) begin miscompares++; $display("FAIL glitch_commit: got %0d want %0d", stb_total, stb0 + 1); end
    for (int n = 0; n < 6; n++) begin
      vectors++;
      if (qd[n] !== mq[n]) begin miscompares++; $display("FAIL glitch_q%0d: got %h want %h", n, qd[n], mq[n]); end
    end
    vectors++;
    if (dp !== mdp) begin miscompares++; $display("FAIL glitch_dp: got %b want %b", dp, mdp); end
  endtask

  task automatic test_bad_segment();
    pulse_clr();
    for (int n = 0; n < 6; n++) dwell(dsel(n), (n == 1) ? 8'h12 : {1'b0, pat[n]}, 6);
    dwell(6'h3F, 8'h00, S + 2);
    vectors++;
    if (q1 !== 4'hF || q0 !== 4'd0 || q5 !== 4'd5) begin
      miscompares++; $display("FAIL badseg_q: q0=%h q1=%h q5=%h want 0/F/5", q0, q1, q5);
    end
    vectors++;
    if (seg_err !== merr || err_cnt !== mcnt) begin
      miscompares++; $display("FAIL badseg_err: err=%b cnt=%0d want %b/%0d", seg_err, err_cnt, merr, mcnt);
    end
  endtask

  task automatic test_bad_dig();
    int stb0;
    pulse_clr();
    stb0 = stb_total;
    for (int n = 0; n < 5; n++) dwell(dsel(n), {1'b1, pat[9 - n]}, 7);
    dwell(6'b001111, {1'b0, pat[0]}, 8);
    dwell(6'h3F, 8'h00, 2);
    vectors++;
    if (seg_err !== 1'b1 || err_cnt !== mcnt || stb_total !== stb0) begin
      miscompares++;
      $display("FAIL baddig_err: err=%b cnt=%0d stb=%0d want 1/%0d/%0d", seg_err, err_cnt, stb_total, mcnt, stb0);
    end
    pulse_clr();
    @(negedge clk);
    vectors++;
    if (seg_err !== 1'b0 || err_cnt !== 8'd0) begin
      miscompares++; $display("FAIL baddig_clr: err=%b cnt=%0d want 0/0", seg_err, err_cnt);
    end
    dwell(dsel(5), {1'b0, pat[3]}, 6);
    dwell(6'h3F, 8'h00, S + 2);
    vectors++;
    if (stb_total !== stb0 + 1) begin miscompares++; $display("FAIL baddig_commit: got %0d want %0d", stb_total, stb0 + 1); end
    for (int n = 0; n < 6; n++) begin
      vectors++;
      if (qd[n] !== mq[n]) begin miscompares++; $display("FAIL baddig_q%0d: got %h want %h", n, qd[n], mq[n]); end
    end
    vectors++;
    if (dp !== mdp) begin miscompares++; $display("FAIL baddig_dp: got %b want %b", dp, mdp); end
  endtask

  task automatic test_clr_collision();
    pulse_clr();
    dwell(dsel(2), 8'h12, S);
    err_clr = 1'b1; dig = 6'h3F; smg = 8'h00;
    @(negedge clk);
    err_clr = 1'b0;
    dwell(6'h3F, 8'h00, S);
    vectors++;
`ifdef SEG_DEC_ERRCNT_EN
    if (seg_err !== 1'b1 || err_cnt !== 8'd1) begin
`else
    if (seg_err !== 1'b1 || err_cnt !== 8'd0) begin
`endif
      miscompares++; $display("FAIL collision: err=%b cnt=%0d want 1/%0d", seg_err, err_cnt, mcnt);
    end
    pulse_clr();
  endtask

  task automatic test_timeout();
    int s0;
    scan_frame(24'h102938, 6'b100001, 5);
    s0 = stb_cyc;
    dwell(6'h3F, 8'h00, TMO + 50);
    vectors++;
    if (fall_cyc - s0 !== TMO) begin
      miscompares++; $display("FAIL timeout_fall: alive fell %0d cycles after stb, want %0d", fall_cyc - s0, TMO);
    end
    vectors++;
    if (alive !== 1'b0) begin miscompares++; $display("FAIL timeout_low: alive=%b want 0", alive); end
    scan_frame(24'h777777, 6'b000000, 6);
    vectors++;
    if (alive !== 1'b1 || q2 !== 4'd7) begin
      miscompares++; $display("FAIL timeout_recover: alive=%b q2=%h want 1/7", alive, q2);
    end
  endtask

  task automatic test_reset_midframe();
    int stb0;
    for (int n = 0; n < 4; n++) dwell(dsel(n), {1'b1, pat[2]}, 6);
    rst_n = 1'b0; dig = 6'h3F; smg = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset(); last_v = IDLE;
    vectors++;
    if ({q0, q1, q2, q3, q4, q5, dp, frame_stb, alive, seg_err, err_cnt} !== 41'h0) begin
      miscompares++; $display("FAIL midreset_outputs: q=%h%h%h%h%h%h dp=%b alive=%b want all 0", q5, q4, q3, q2, q1, q0, dp, alive);
    end
    stb0 = stb_total;
    for (int n = 0; n < 5; n++) dwell(dsel(n), {1'b0, pat[n + 4]}, 6);
    dwell(6'h3F, 8'h00, S + 2);
    vectors++;
    if (stb_total !== stb0) begin miscompares++; $display("FAIL midreset_partial: got %0d want %0d", stb_total, stb0); end
    dwell(dsel(5), {1'b0, pat[0]}, 6);
    dwell(6'h3F, 8'h00, S + 2);
    vectors++;
    if (stb_total !== stb0 + 1 || q0 !== 4'd4 || q4 !== 4'd8 || q5 !== 4'd0) begin
      miscompares++; $display("FAIL midreset_frame: stb=%0d q0=%h q4=%h q5=%h want %0d/4/8/0", stb_total, q0, q4, q5, stb0 + 1);
    end
  endtask

  task automatic test_random();
    logic [6:0] s7;
    logic [5:0] d;
    logic [3:0] c;
    for (int f = 0; f < 15; f++) begin
      for (int n = 0; n < 6; n++) begin
        if ($urandom_range(2) == 0) dwell(6'($urandom), 8'($urandom), $urandom_range(S - 1, 1));
        if ($urandom_range(5) == 0) dwell(dsel(n), {1'b0, pat[$urandom_range(9)]}, S + $urandom_range(3));
        if ($urandom_range(9) == 0) begin
          d = 6'($urandom) & 6'b110110;
          dwell(d, 8'h7E, S + 1);
        end
        c = 4'($urandom_range(11));
        if (c == 4'd10)      s7 = 7'h00;
        else if (c == 4'd11) s7 = 7'h1C;
        else                 s7 = pat[c];
        dwell(dsel(n), {1'($urandom), s7}, S + $urandom_range(4));
      end
      dwell(6'h3F, 8'h00, S + 2);
      if ($urandom_range(3) == 0) pulse_clr();
      for (int n = 0; n < 6; n++) begin
        vectors++;
        if (qd[n] !== mq[n]) begin miscompares++; $display("FAIL rand%0d_q%0d: got %h want %h", f, n, qd[n], mq[n]); end
      end
      vectors++;
      if (dp !== mdp || seg_err !== merr || err_cnt !== mcnt) begin
        miscompares++;
        $display("FAIL rand%0d_flags: dp=%b err=%b cnt=%0d want %b/%b/%0d", f, dp, seg_err, err_cnt, mdp, merr, mcnt);
      end
      vectors++;
      if (stb_total !== mframes || alive !== 1'b1) begin
        miscompares++; $display("FAIL rand%0d_frames: stb=%0d alive=%b want %0d/1", f, stb_total, alive, mframes);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; err_clr = 1'b0; dig = 6'h3F; smg = 8'h00;
    @(negedge clk);
    test_reset();
    test_basic_frame();
    test_glitch();
    test_bad_segment();
    test_bad_dig();
    test_clr_collision();
    test_timeout();
    test_reset_midframe();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
